// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals of the two-requester ALU arbiter.
// slave: arbiter side; master: requesters, ALU and response consumer.
interface alu_arbiter_if;
    logic        req_valid_0;
    logic        req_valid_1;
    logic        req_ready_0;
    logic        req_ready_1;
    logic [31:0] req_in1_0;
    logic [31:0] req_in1_1;
    logic [31:0] req_in2_0;
    logic [31:0] req_in2_1;
    logic [5:0]  req_funct_0;
    logic [5:0]  req_funct_1;
    logic        req_sign_0;
    logic        req_sign_1;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [5:0]  alu_funct;
    logic        alu_sign;
    logic [31:0] alu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id;
    logic        busy;

    modport slave (
        input  req_valid_0, req_valid_1, req_in1_0, req_in1_1, req_in2_0, req_in2_1,
        input  req_funct_0, req_funct_1, req_sign_0, req_sign_1, alu_out, rsp_ready,
        output req_ready_0, req_ready_1, alu_in1, alu_in2, alu_funct, alu_sign,
        output rsp_valid, rsp_data, rsp_id, busy
    );

    modport master (
        output req_valid_0, req_valid_1, req_in1_0, req_in1_1, req_in2_0, req_in2_1,
        output req_funct_0, req_funct_1, req_sign_0, req_sign_1, alu_out, rsp_ready,
        input  req_ready_0, req_ready_1, alu_in1, alu_in2, alu_funct, alu_sign,
        input  rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU (IDLE -> EXEC -> DONE).
// Define ALU_ARBITER_RR_EN for round-robin contention; default is fixed priority to requester 0.
module alu_arbiter (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus,
    output logic [1:0]    state_dbg
);
    // Handshakes: a request transfers on a rising edge where req_valid_k and req_ready_k
    // are both high; a response transfers on a rising edge where rsp_valid and rsp_ready are high.
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    state_t state;
    state_t state_next;
    logic   eligible;
    logic   prefer_1;
    logic   grant_0;
    logic   grant_1;
    logic   accept;
    logic   op_id;

`ifdef ALU_ARBITER_RR_EN
    logic rr_ptr;

    // Pointer always moves to the requester that lost (or was not served) this accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= 1'b0;
        else if (accept)
            rr_ptr <= grant_0;
    end

    assign prefer_1 = rr_ptr;
`else
    assign prefer_1 = 1'b0;
`endif

    always_comb begin
        eligible = 1'b0;
        grant_0  = 1'b0;
        grant_1  = 1'b0;
        // Gated by reset so req_ready is low for the whole reset interval.
        eligible = !reset && ((state == IDLE) || ((state == DONE) && bus.rsp_ready));
        grant_0  = eligible && bus.req_valid_0 && (!bus.req_valid_1 || !prefer_1);
        grant_1  = eligible && bus.req_valid_1 && (!bus.req_valid_0 || prefer_1);
    end

    assign accept = grant_0 || grant_1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = EXEC;
            EXEC: state_next = DONE;
            DONE: begin
                if (bus.rsp_ready)
                    state_next = accept ? EXEC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.alu_in1   <= 32'd0;
            bus.alu_in2   <= 32'd0;
            bus.alu_funct <= 6'b000000;
            bus.alu_sign  <= 1'b0;
            op_id         <= 1'b0;
            bus.rsp_data  <= 32'd0;
            bus.rsp_id    <= 1'b0;
        end else begin
            if (grant_0) begin
                bus.alu_in1   <= bus.req_in1_0;
                bus.alu_in2   <= bus.req_in2_0;
                bus.alu_funct <= bus.req_funct_0;
                bus.alu_sign  <= bus.req_sign_0;
                op_id         <= 1'b0;
            end else if (grant_1) begin
                bus.alu_in1   <= bus.req_in1_1;
                bus.alu_in2   <= bus.req_in2_1;
                bus.alu_funct <= bus.req_funct_1;
                bus.alu_sign  <= bus.req_sign_1;
                op_id         <= 1'b1;
            end
            // rsp_id is separate from op_id so it stays stable while DONE waits.
            if (state == EXEC) begin
                bus.rsp_data <= bus.alu_out;
                bus.rsp_id   <= op_id;
            end
        end
    end

    assign bus.req_ready_0 = grant_0;
    assign bus.req_ready_1 = grant_1;
    assign bus.rsp_valid   = (state == DONE);
    assign bus.busy        = (state != IDLE);
    assign state_dbg       = state;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on alu_out.
// Contention expectations follow ALU_ARBITER_RR_EN when defined.
module tb_alu_arbiter;
    logic       clk;
    logic       reset;
    logic [1:0] state_dbg;
    int         errors;
    int         checks;
    int         exp_id[4];

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (bus.alu_funct)
            6'b000000: bus.alu_out = bus.alu_in1 + bus.alu_in2;
            6'b000001: bus.alu_out = bus.alu_in1 - bus.alu_in2;
            6'b011000: bus.alu_out = bus.alu_in1 & bus.alu_in2;
            6'b110011: bus.alu_out = bus.alu_in1 | bus.alu_in2;
            default:   bus.alu_out = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
        bus.req_valid_0 = v;
        bus.req_in1_0   = a;
        bus.req_in2_0   = b;
        bus.req_funct_0 = f;
        bus.req_sign_0  = 1'b0;
    endtask

    task automatic drive_req1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
        bus.req_valid_1 = v;
        bus.req_in1_1   = a;
        bus.req_in2_1   = b;
        bus.req_funct_1 = f;
        bus.req_sign_1  = 1'b1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"},   {31'd0, bus.busy},        32'd0);
        chk({tag, "_rspv"},   {31'd0, bus.rsp_valid},   32'd0);
        chk({tag, "_rdy0"},   {31'd0, bus.req_ready_0}, 32'd0);
        chk({tag, "_rdy1"},   {31'd0, bus.req_ready_1}, 32'd0);
        chk({tag, "_in1"},    bus.alu_in1,              32'd0);
        chk({tag, "_in2"},    bus.alu_in2,              32'd0);
        chk({tag, "_funct"},  {26'd0, bus.alu_funct},   32'd0);
        chk({tag, "_sign"},   {31'd0, bus.alu_sign},    32'd0);
        chk({tag, "_data"},   bus.rsp_data,             32'd0);
        chk({tag, "_id"},     {31'd0, bus.rsp_id},      32'd0);
        chk({tag, "_state"},  {30'd0, state_dbg},       32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
`ifdef ALU_ARBITER_RR_EN
        exp_id = '{0, 1, 0, 1};
`else
        exp_id = '{0, 0, 0, 0};
`endif
        reset = 1'b1;
        bus.rsp_ready = 1'b0;
        // Valid during reset must not produce a ready.
        drive_req0(1'b1, 32'd5, 32'd7, 6'b000000);
        drive_req1(1'b1, 32'd1, 32'd1, 6'b000000);
        #2;
        chk_reset_values("reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        drive_req1(1'b0, 32'd0, 32'd0, 6'b000000);
        bus.rsp_ready = 1'b1;
        #1;

        // Single op: 5 + 7
        chk("single_rdy0", {31'd0, bus.req_ready_0}, 32'd1);
        chk("single_rdy1", {31'd0, bus.req_ready_1}, 32'd0);
        tick();
        drive_req0(1'b1, 32'd99, 32'd99, 6'b000001);
        drive_req1(1'b1, 32'd99, 32'd99, 6'b000001);
        #1;
        chk("exec_busy",  {31'd0, bus.busy},        32'd1);
        chk("exec_rspv",  {31'd0, bus.rsp_valid},   32'd0);
        chk("exec_rdy0",  {31'd0, bus.req_ready_0}, 32'd0);
        chk("exec_rdy1",  {31'd0, bus.req_ready_1}, 32'd0);
        chk("exec_in1",   bus.alu_in1,              32'd5);
        chk("exec_in2",   bus.alu_in2,              32'd7);
        chk("exec_funct", {26'd0, bus.alu_funct},   32'd0);
        drive_req0(1'b0, 32'd0, 32'd0, 6'b000000);
        drive_req1(1'b0, 32'd0, 32'd0, 6'b000000);
        tick();
        chk("single_rspv", {31'd0, bus.rsp_valid}, 32'd1);
        chk("single_data", bus.rsp_data,           32'd12);
        chk("single_id",   {31'd0, bus.rsp_id},    32'd0);
        tick();
        chk("retire_rspv", {31'd0, bus.rsp_valid}, 32'd0);
        chk("retire_busy", {31'd0, bus.busy},      32'd0);

        // Backpressure: hold DONE for 4 cycles with req1 waiting
        bus.rsp_ready = 1'b0;
        drive_req0(1'b1, 32'd5, 32'd7, 6'b000000);
        tick();
        drive_req0(1'b0, 32'd0, 32'd0, 6'b000000);
        tick();
        drive_req1(1'b1, 32'h10, 32'h20, 6'b000000);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_rspv", {31'd0, bus.rsp_valid},   32'd1);
            chk("bp_data", bus.rsp_data,             32'd12);
            chk("bp_id",   {31'd0, bus.rsp_id},      32'd0);
            chk("bp_rdy0", {31'd0, bus.req_ready_0}, 32'd0);
            chk("bp_rdy1", {31'd0, bus.req_ready_1}, 32'd0);
            chk("bp_in1",  bus.alu_in1,              32'd5);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_rdy1", {31'd0, bus.req_ready_1}, 32'd1);
        tick();
        drive_req1(1'b0, 32'd0, 32'd0, 6'b000000);
        chk("bp_exec_rspv", {31'd0, bus.rsp_valid}, 32'd0);
        chk("bp_exec_in1",  bus.alu_in1,            32'h10);
        tick();
        chk("bp_next_data", bus.rsp_data,          32'h30);
        chk("bp_next_id",   {31'd0, bus.rsp_id},   32'd1);

        // Zero-gap: req1 accepted on the edge that retires the response
        drive_req1(1'b1, 32'd3, 32'd3, 6'b000000);
        #1;
        chk("zg_rdy1", {31'd0, bus.req_ready_1}, 32'd1);
        tick();
        drive_req1(1'b0, 32'd0, 32'd0, 6'b000000);
        chk("zg_exec_rspv", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        chk("zg_rspv", {31'd0, bus.rsp_valid}, 32'd1);
        chk("zg_data", bus.rsp_data,           32'd6);
        chk("zg_id",   {31'd0, bus.rsp_id},    32'd1);

        // Contention: 9-4 on req0, 0xF0 & 0x3C on req1, one result per 2 cycles
        drive_req0(1'b1, 32'd9, 32'd4, 6'b000001);
        drive_req1(1'b1, 32'hF0, 32'h3C, 6'b011000);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("cont_rdy0", {31'd0, bus.req_ready_0}, (exp_id[i] == 0) ? 32'd1 : 32'd0);
            chk("cont_rdy1", {31'd0, bus.req_ready_1}, (exp_id[i] == 1) ? 32'd1 : 32'd0);
            tick();
            chk("cont_exec_rspv", {31'd0, bus.rsp_valid}, 32'd0);
            tick();
            chk("cont_rspv", {31'd0, bus.rsp_valid}, 32'd1);
            chk("cont_data", bus.rsp_data, (exp_id[i] == 0) ? 32'd5 : 32'h30);
            chk("cont_id",   {31'd0, bus.rsp_id}, exp_id[i][31:0]);
        end
        drive_req0(1'b0, 32'd0, 32'd0, 6'b000000);
        #1;
        chk("cont_drop_rdy1", {31'd0, bus.req_ready_1}, 32'd1);
        tick();
        drive_req1(1'b0, 32'd0, 32'd0, 6'b000000);
        tick();
        chk("cont_drop_data", bus.rsp_data,        32'h30);
        chk("cont_drop_id",   {31'd0, bus.rsp_id}, 32'd1);
        tick();
        chk("cont_idle_busy", {31'd0, bus.busy}, 32'd0);

        // Reset mid-EXEC discards the operation
        drive_req1(1'b1, 32'd3, 32'd3, 6'b110011);
        tick();
        drive_req1(1'b0, 32'd0, 32'd0, 6'b000000);
        chk("rst_exec_state", {30'd0, state_dbg}, 32'd1);
        chk("rst_exec_funct", {26'd0, bus.alu_funct}, 32'h33);
        #2 reset = 1'b1;
        #1;
        chk_reset_values("rst_exec");
        @(posedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_rspv", {31'd0, bus.rsp_valid}, 32'd0);
            chk("post_rst_busy", {31'd0, bus.busy},      32'd0);
        end

        // Pointer back at requester 0 after reset; first edge grants
        drive_req0(1'b1, 32'd9, 32'd4, 6'b000001);
        drive_req1(1'b1, 32'hF0, 32'h3C, 6'b011000);
        #1;
        chk("post_rst_rdy0", {31'd0, bus.req_ready_0}, 32'd1);
        chk("post_rst_rdy1", {31'd0, bus.req_ready_1}, 32'd0);
        tick();
        drive_req0(1'b0, 32'd0, 32'd0, 6'b000000);
        drive_req1(1'b0, 32'd0, 32'd0, 6'b000000);
        chk("post_rst_busy1", {31'd0, bus.busy}, 32'd1);
        chk("post_rst_in1",   bus.alu_in1,       32'd9);
        tick();
        chk("post_rst_data", bus.rsp_data, 32'd5);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports, per requester k in {0,1}: req_valid_k  input  1  request present.
REQ-004 SHALL have ports: req_ready_k  output  1  request accepted this cycle when high with req_valid_k.
REQ-005 SHALL have ports: req_in1_k, req_in2_k  input  32  ALU operands.
REQ-006 SHALL have ports: req_funct_k  input  6  ALU function code; req_sign_k  input  1  signed-compare select.
REQ-007 SHALL have ports: alu_in1, alu_in2  output  32; alu_funct  output  6; alu_sign  output  1  registered drive to the shared combinational ALU.
REQ-008 SHALL have port: alu_out  input  32  combinational ALU result.
REQ-009 SHALL have ports: rsp_valid  output  1; rsp_ready  input  1; rsp_data  output  32; rsp_id  output  1  requester that issued the result.
REQ-010 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, EXEC, DONE.
REQ-012 Grant eligibility: IDLE, or DONE with rsp_ready=1.
REQ-013 When eligible and exactly one req_valid_k=1, SHALL assert req_ready_k for that k only; req_ready of the other requester 0.
REQ-014 When eligible and both valid, SHALL grant per REQ-030/031; never assert both req_ready together.
REQ-015 On accept edge (req_valid_k & req_ready_k): latch that requester's in1/in2/funct/sign into alu_* registers, latch id, go to EXEC.
REQ-016 alu_* outputs SHALL hold their last latched value until next accept; never change mid-EXEC.
REQ-017 EXEC lasts exactly one cycle; at its end capture alu_out into rsp_data, set rsp_valid=1, go to DONE.
REQ-018 Latency: rsp_valid rises exactly 2 edges after the edge where the request was accepted-presented (accept edge +1).
REQ-019 DONE, rsp_ready=0: hold rsp_data, rsp_id, rsp_valid=1; no grants; stay DONE.
REQ-020 DONE, rsp_ready=1, new grant: response consumed and new op enters EXEC same edge; rsp_valid=0 during that EXEC cycle.
REQ-021 DONE, rsp_ready=1, no request: rsp_valid->0, go IDLE.
REQ-022 EXEC: req_ready_0=req_ready_1=0 regardless of inputs.
REQ-023 Throughput: back-to-back with rsp_ready=1 SHALL sustain one result per 2 cycles.
REQ-024 rsp_data SHALL be the unmodified 32-bit alu_out; no width change, no sign handling in arbiter.
REQ-025 req_ready_k MAY depend combinationally on req_valid of both requesters and rsp_ready; SHALL NOT depend on alu_out.

Reset
REQ-026 On reset assertion, immediately: state IDLE, rsp_valid=0, req_ready_0/1=0, busy=0.
REQ-027 Reset values: alu_in1=0, alu_in2=0, alu_funct=6'b000000, alu_sign=0, rsp_data=0, rsp_id=0, round-robin pointer=0 (requester 0 favoured).
REQ-028 Reset mid-EXEC or mid-DONE SHALL discard the in-flight operation; no response issued after release.
REQ-029 First grant possible on first rising edge after reset deasserts.

Configuration
REQ-030 With macro ALU_ARBITER_RR_EN defined: round-robin; on contention grant requester favoured by pointer; after every accept pointer SHALL point to the non-granted requester.
REQ-031 Without ALU_ARBITER_RR_EN: fixed priority, requester 0 always wins contention; no pointer state.

Verification
REQ-032 Single op: req0 in1=5, in2=7, funct=000000 -> rsp_valid 2 edges later, rsp_data=12, rsp_id=0.
REQ-033 Contention, RR_EN: both valid continuously, req0 funct=000001 (9-4), req1 funct=011000 (0xF0&0x3C) -> rsp sequence 5(id0), 0x30(id1), 5(id0), alternating.
REQ-034 Contention, no RR_EN: same stimulus -> all responses id0 until req_valid_0 drops, then id1.
REQ-035 Backpressure: rsp_ready=0 for 4 cycles in DONE with rsp_data=12 -> rsp_data/rsp_id stable, req_ready both 0; on rsp_ready=1 new grant same edge.
REQ-036 Reset mid-EXEC: accept req1 (in1=3,in2=3,funct=110011), assert reset in EXEC -> rsp_valid never rises, all outputs at reset values.
REQ-037 Zero-gap: req1 valid in DONE with rsp_ready=1 -> accepted same edge response retires; next rsp 2 edges later.
